ycconfig_loader: RTL
====================

# ycconfig_loader

Serial configuration transmitter for a chain of `ycconfig` cells. It accepts 3-bit cell codes from a host over a valid/ready handshake and buffers them in a small FIFO. Each code is shifted MSB-first onto `cbitin`, with the `confclk` waveform generated from the system clock. It sits between the host/bus register block and the first `ycconfig` cell of a Morphle Logic array.

## Interface
Parameters:
- `CELLS`, 16: number of `ycconfig` cells in the driven chain (≥1).
- `HALF`, 2: system-clock cycles per `confclk` phase (≥1).
- `FIFO_AW`, 2: FIFO address width; depth is 2^FIFO_AW.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host presents a code.
- `in_ready`  out  1  FIFO not full.
- `in_code`  in  3  cell code: space=000, +=001, -=010, |=011, 1=100, 0=101, Y=110, N=111.
- `confclk`  out  1  configuration clock to the chain (registered).
- `cbitin`  out  1  serial data to the chain (registered).
- `cbitout`  in  1  serial data returned from the last cell of the chain.
- `busy`  out  1  FIFO non-empty or shifter not IDLE.
- `done`  out  1  one-cycle pulse when the CELLS-th code of a frame has been fully shifted.
- `rb_code`  out  3  readback code (only with the macro).
- `rb_valid`  out  1  one-cycle readback strobe (only with the macro).

## Operation
- A code is accepted on a `clk` edge where `in_valid && in_ready` is true. It is written into the FIFO.
- Shifter FSM states:
  - IDLE: `confclk`=0, `cbitin`=0.
  - SETUP: `confclk`=0, `cbitin` holds the current bit, lasts HALF cycles.
  - HIGH: `confclk`=1, lasts HALF cycles.
- IDLE→SETUP when the FIFO is non-empty. The head is popped and its bit 2 is driven on `cbitin`.
- SETUP→HIGH after HALF cycles.
- HIGH→SETUP after HALF cycles when another bit remains in the code, or when the code is finished and the FIFO is non-empty. Bit order is 2, 1, 0. The next bit or next code MSB is driven on the same edge that lowers `confclk`.
- HIGH→IDLE when the code is finished and the FIFO is empty.
- Consecutive codes have no gap between them.
- Cell counter runs 0..CELLS-1 and increments at the end of each code. On wrap to 0, `done` pulses for one cycle.
- A simultaneous FIFO push and pop is legal. FIFO occupancy is unchanged, and `in_ready` stays high when the FIFO is full but popping.
- Reset at any point:
  - FIFO is flushed, counters clear, FSM goes to IDLE.
  - `confclk`=0 and `cbitin`=0 immediately.
  - The chain may be partially shifted; the host must reload a full frame of CELLS codes.
- Reset values: `in_ready`=1, `confclk`=0, `cbitin`=0, `busy`=0, `done`=0, `rb_code`=000, `rb_valid`=0.

## Timing
- Code accepted at edge T with the shifter IDLE:
  - `cbitin` = bit 2 from T+1.
  - `confclk` rises at T+1+HALF and falls at T+1+2·HALF.
  - Each bit takes 2·HALF cycles; a code takes 6·HALF cycles.
- `cbitin` never changes while `confclk`=1. Setup and hold to the rising edge are each ≥ HALF cycles.
- `done` is asserted on the edge that ends the last HIGH phase of the frame's final code.
- `busy` falls on the same edge the FSM enters IDLE.

## Configuration
- `YCCONFIG_READBACK_EN` defined:
  - `cbitout` is sampled in the last cycle of every SETUP phase, i.e. the value present before the `confclk` rise.
  - Three consecutive samples are packed first-sample-into-bit-2.
  - `rb_code` is updated and `rb_valid` pulses for one cycle on the edge after the third sample.
  - This returns the chain's previous configuration, one code per shifted code, with a delay of CELLS codes.
- Not defined: `rb_code` is tied to 000, `rb_valid` to 0, and `cbitout` is ignored. No sampling registers are built.

## Test plan
- HALF=2, push `+` (001) at T into idle: `cbitin` 0,0,1 at T+1, T+5, T+9. `confclk` high over T+3..T+4, T+7..T+8, T+11..T+12. IDLE at T+13 with `cbitin`=0.
- Push 4 codes back-to-back with FIFO_AW=2, holding `in_valid`: `in_ready` drops only when 4 entries are queued. Codes are contiguous on `cbitin` with no idle cycles.
- CELLS=2, push `Y` then `N`: `done` pulses exactly once, at the final `confclk` fall. A third code restarts the count.
- Assert `reset_n` low during a HIGH phase of the 2nd bit: `confclk` and `cbitin` drop to 0 asynchronously. After release, `busy`=0 and `in_ready`=1.
- With `YCCONFIG_READBACK_EN`, `cbitout` looped through a 2-cell `ycconfig` model, frame `-`,`1` then frame `0`,`|`: the second frame returns `rb_code` 010 then 100.
- HALF=1 with a full 8-code sweep 000..111: `cbitin` matches every code MSB-first, and each code takes 6 cycles.

Source files
------------

// File: rtl/ycconfig_loader.sv
// ycconfig_loader: serial configuration transmitter for a chain of ycconfig cells.
// Accepts 3-bit cell codes over a valid/ready handshake and buffers them in a FIFO.
// Each code is shifted MSB-first onto cbitin, with confclk generated from clk.
//
// Optional feature macro: YCCONFIG_READBACK_EN
//   When defined, cbitout is sampled just before each confclk rise.
//   Every three samples are returned on rb_code with a one-cycle rb_valid strobe.
//   When undefined, rb_code/rb_valid are tied low and cbitout is ignored.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   in_valid  in   host presents a code
//   in_ready  out  FIFO can accept (not full, or popping this cycle)
//   in_code   in   3-bit cell code
//   confclk   out  configuration clock to the chain (registered)
//   cbitin    out  serial data to the chain (registered)
//   cbitout   in   serial data returned from the last cell
//   busy      out  FIFO non-empty or shifter active (registered)
//   done      out  one-cycle pulse when a frame of CELLS codes has been shifted
//   rb_code   out  readback code (readback build only, else 000)
//   rb_valid  out  readback strobe (readback build only, else 0)
module ycconfig_loader #(
  parameter int unsigned CELLS   = 16,
  parameter int unsigned HALF    = 2,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  output logic       confclk,
  output logic       cbitin,
  input  logic       cbitout,
  output logic       busy,
  output logic       done,
  output logic [2:0] rb_code,
  output logic       rb_valid
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;
  localparam int unsigned PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned CC_W  = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [2:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count_nx;
  logic [2:0]         w_head;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign in_ready   = !w_full || w_pop;
  assign w_push     = in_valid && in_ready;
  assign w_count_nx = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head     = r_mem[r_rptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_code;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_AW'(1);
      end
      r_count <= w_count_nx;
    end
  end

  // ------------------------------------------------------------- shifter
  state_t            r_state;
  state_t            w_state_nx;
  logic [PH_W-1:0]   r_phase;
  logic [PH_W-1:0]   w_phase_nx;
  logic [2:0]        r_shreg;
  logic [2:0]        w_shreg_nx;
  logic [1:0]        r_bit;
  logic [1:0]        w_bit_nx;
  logic [CC_W-1:0]   r_cell;
  logic [CC_W-1:0]   w_cell_nx;
  logic              r_confclk;
  logic              w_confclk_nx;
  logic              r_cbitin;
  logic              w_cbitin_nx;
  logic              r_busy;
  logic              w_busy_nx;
  logic              r_done;
  logic              w_done_nx;
  logic              w_phase_end;
  logic              w_sample;

  assign w_phase_end = (r_phase == PH_W'(HALF - 1));

  // State and datapath registers of the shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_shreg   <= '0;
      r_bit     <= '0;
      r_cell    <= '0;
      r_confclk <= 1'b0;
      r_cbitin  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_phase   <= w_phase_nx;
      r_shreg   <= w_shreg_nx;
      r_bit     <= w_bit_nx;
      r_cell    <= w_cell_nx;
      r_confclk <= w_confclk_nx;
      r_cbitin  <= w_cbitin_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
    end
  end

  // Next-state logic; the next bit or next code MSB is launched on the
  // same edge that lowers confclk so codes stream without gaps.
  always_comb begin
    w_state_nx   = r_state;
    w_phase_nx   = r_phase;
    w_shreg_nx   = r_shreg;
    w_bit_nx     = r_bit;
    w_cell_nx    = r_cell;
    w_confclk_nx = r_confclk;
    w_cbitin_nx  = r_cbitin;
    w_done_nx    = 1'b0;
    w_pop        = 1'b0;
    w_sample     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_confclk_nx = 1'b0;
        w_cbitin_nx  = 1'b0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nx  = ST_SETUP;
          w_phase_nx  = '0;
          w_shreg_nx  = w_head;
          w_bit_nx    = 2'd2;
          w_cbitin_nx = w_head[2];
        end
      end

      ST_SETUP: begin
        if (w_phase_end) begin
          w_state_nx   = ST_HIGH;
          w_phase_nx   = '0;
          w_confclk_nx = 1'b1;
          w_sample     = 1'b1;
        end else begin
          w_phase_nx = r_phase + PH_W'(1);
        end
      end

      ST_HIGH: begin
        if (w_phase_end) begin
          w_phase_nx   = '0;
          w_confclk_nx = 1'b0;
          if (r_bit != 2'd0) begin
            w_state_nx  = ST_SETUP;
            w_bit_nx    = r_bit - 2'd1;
            w_shreg_nx  = {r_shreg[1:0], 1'b0};
            w_cbitin_nx = r_shreg[1];
          end else begin
            // Code finished: advance the cell counter, pulse done on frame wrap.
            if (r_cell == CC_W'(CELLS - 1)) begin
              w_cell_nx = '0;
              w_done_nx = 1'b1;
            end else begin
              w_cell_nx = r_cell + CC_W'(1);
            end
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_state_nx  = ST_SETUP;
              w_shreg_nx  = w_head;
              w_bit_nx    = 2'd2;
              w_cbitin_nx = w_head[2];
            end else begin
              w_state_nx  = ST_IDLE;
              w_cbitin_nx = 1'b0;
            end
          end
        end else begin
          w_phase_nx = r_phase + PH_W'(1);
        end
      end

      default: begin
        w_state_nx   = ST_IDLE;
        w_confclk_nx = 1'b0;
        w_cbitin_nx  = 1'b0;
      end
    endcase
  end

  // busy follows the post-edge FIFO occupancy and FSM state.
  assign w_busy_nx = (w_state_nx != ST_IDLE) || (w_count_nx != '0);

  assign confclk = r_confclk;
  assign cbitin  = r_cbitin;
  assign busy    = r_busy;
  assign done    = r_done;

  // ------------------------------------------------------------ readback
`ifdef YCCONFIG_READBACK_EN
  logic [1:0] r_rb_sh;
  logic [1:0] r_rb_cnt;
  logic [2:0] r_rb_code;
  logic       r_rb_valid;

  // Sample cbitout at the end of each SETUP phase; pack three samples MSB-first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rb_sh    <= '0;
      r_rb_cnt   <= '0;
      r_rb_code  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_sample) begin
        if (r_rb_cnt == 2'd2) begin
          r_rb_code  <= {r_rb_sh, cbitout};
          r_rb_valid <= 1'b1;
          r_rb_cnt   <= '0;
        end else begin
          r_rb_sh  <= {r_rb_sh[0], cbitout};
          r_rb_cnt <= r_rb_cnt + 2'd1;
        end
      end
    end
  end

  assign rb_code  = r_rb_code;
  assign rb_valid = r_rb_valid;
`else
  logic w_unused_rb;

  assign w_unused_rb = cbitout ^ w_sample;
  assign rb_code     = 3'b000;
  assign rb_valid    = 1'b0;
`endif

endmodule
